// File: rtl/md4_round2_if.sv
// Handshake and data bundle for the MD4 round-2 engine: block-in channel
// from the round-1 stage and result channel towards the round-3 stage.
interface md4_round2_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  a_in;
  logic [31:0]  b_in;
  logic [31:0]  c_in;
  logic [31:0]  d_in;
  logic [511:0] x_in;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_a;
  logic [31:0]  out_b;
  logic [31:0]  out_c;
  logic [31:0]  out_d;

  modport master (
    output in_valid, a_in, b_in, c_in, d_in, x_in, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_c, out_d
  );

  modport slave (
    input  in_valid, a_in, b_in, c_in, d_in, x_in, out_ready,
    output in_ready, out_valid, out_a, out_b, out_c, out_d
  );
endinterface

// File: rtl/md4_round2_iter.sv
// Iterative MD4 round 2: one G-step per clock through a single shared step
// datapath, 16 cycles per block, valid/ready on both sides.
module md4_round2_iter #(
  parameter logic [31:0] ROUND_CONST = 32'h5A827999
) (
  input  logic         clk,
  input  logic         rst_n,
  md4_round2_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, next_state;
  logic [3:0]   step;
  logic [31:0]  work_a, work_b, work_c, work_d;
  logic [511:0] msg;

  logic         accept;
  logic [31:0]  r0, r1, r2, r3;
  logic [31:0]  x_word, g_val, sum, rotated;

  assign accept = bus.in_valid && (state == IDLE);

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    next_state    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) next_state = RUN;
      end
      RUN: begin
        if (step == 4'd15) next_state = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Role rotation a,d,c,b: the step counter's low bits pick which working
  // word is the destination and how the other three feed G.
  always_comb begin
    r0 = work_a;
    r1 = work_b;
    r2 = work_c;
    r3 = work_d;
    case (step[1:0])
      2'd0: begin r0 = work_a; r1 = work_b; r2 = work_c; r3 = work_d; end
      2'd1: begin r0 = work_d; r1 = work_a; r2 = work_b; r3 = work_c; end
      2'd2: begin r0 = work_c; r1 = work_d; r2 = work_a; r3 = work_b; end
      default: begin r0 = work_b; r1 = work_c; r2 = work_d; r3 = work_a; end
    endcase
  end

  // Message word order 0,4,8,12,1,5,... is the step index with its two
  // 2-bit halves swapped.
  assign x_word = msg[{step[1:0], step[3:2], 5'd0} +: 32];
  assign g_val  = (r1 & r2) | (r1 & r3) | (r2 & r3);
  assign sum    = r0 + g_val + x_word + ROUND_CONST;

  always_comb begin
    rotated = sum;
    case (step[1:0])
      2'd0:    rotated = {sum[28:0], sum[31:29]};
      2'd1:    rotated = {sum[26:0], sum[31:27]};
      2'd2:    rotated = {sum[22:0], sum[31:23]};
      default: rotated = {sum[18:0], sum[31:19]};
    endcase
  end

  // NOTE: the 512-bit message register is reset along with the working
  // words so a block aborted by reset leaves no stale data behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_a <= '0;
      work_b <= '0;
      work_c <= '0;
      work_d <= '0;
      msg    <= '0;
      step   <= '0;
    end else if (accept) begin
      work_a <= bus.a_in;
      work_b <= bus.b_in;
      work_c <= bus.c_in;
      work_d <= bus.d_in;
      msg    <= bus.x_in;
      step   <= '0;
    end else if (state == RUN) begin
      case (step[1:0])
        2'd0:    work_a <= rotated;
        2'd1:    work_d <= rotated;
        2'd2:    work_c <= rotated;
        default: work_b <= rotated;
      endcase
      step <= step + 4'd1;
    end
  end

  assign bus.out_a = work_a;
  assign bus.out_b = work_b;
  assign bus.out_c = work_c;
  assign bus.out_d = work_d;

endmodule
